// File: rtl/fir_filt_if.sv
// Sample/coefficient/result bundle for fir_filt; master drives samples and coefficient writes.
interface fir_filt_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 3,
    parameter int OUT_W  = 8
) ();
    localparam int AW = $clog2(TAPS);

    logic              i_valid;
    logic [DATA_W-1:0] i_x;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              o_valid;
    logic [OUT_W-1:0]  o_y;

    modport master (
        output i_valid, i_x, coef_we, coef_addr, coef_data,
        input  o_valid, o_y
    );

    modport slave (
        input  i_valid, i_x, coef_we, coef_addr, coef_data,
        output o_valid, o_y
    );
endinterface

// File: rtl/fir_filt.sv
// Two-stage pipelined FIR with writable coefficients; o_valid follows i_valid by exactly 2 cycles, no backpressure.
// Optional output saturation with FIR_FILT_SAT_EN; wrap-around narrowing otherwise.
module fir_filt #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 3,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    fir_filt_if.slave   bus
);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + $clog2(TAPS);
    localparam int AW    = $clog2(TAPS);

    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [COEF_W-1:0] coef_d [TAPS];
    logic signed [DATA_W-1:0] dly_q  [TAPS-1];
    logic signed [DATA_W-1:0] dly_d  [TAPS-1];
    logic signed [PW-1:0]     prod_q [TAPS];
    logic signed [PW-1:0]     prod_d [TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     v1_q, v1_d;
    logic                     ovld_q, ovld_d;
    logic signed [DATA_W-1:0] x_in;

    always_comb begin
        x_in = $signed(bus.i_x);

        coef_d = coef_q;
        for (int k = 0; k < TAPS; k++) begin
            if (bus.coef_we && bus.coef_addr == AW'(k)) begin
                coef_d[k] = bus.coef_data;
            end
        end

        // Products use pre-write coefficients and pre-shift history of this cycle.
        dly_d  = dly_q;
        prod_d = prod_q;
        if (bus.i_valid) begin
            dly_d[0] = x_in;
            for (int j = 1; j < TAPS - 1; j++) begin
                dly_d[j] = dly_q[j-1];
            end
            prod_d[0] = PW'(coef_q[0]) * PW'(x_in);
            for (int k = 1; k < TAPS; k++) begin
                prod_d[k] = PW'(coef_q[k]) * PW'(dly_q[k-1]);
            end
        end

        acc_d = acc_q;
        if (v1_q) begin
            acc_d = '0;
            for (int k = 0; k < TAPS; k++) begin
                acc_d = acc_d + ACC_W'(prod_q[k]);
            end
        end

        v1_d   = bus.i_valid;
        ovld_d = v1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= COEF_W'(1);
                prod_q[k] <= '0;
            end
            for (int j = 0; j < TAPS - 1; j++) begin
                dly_q[j] <= '0;
            end
            acc_q  <= '0;
            v1_q   <= 1'b0;
            ovld_q <= 1'b0;
        end else begin
            coef_q <= coef_d;
            dly_q  <= dly_d;
            prod_q <= prod_d;
            acc_q  <= acc_d;
            v1_q   <= v1_d;
            ovld_q <= ovld_d;
        end
    end

    assign bus.o_valid = ovld_q;

`ifdef FIR_FILT_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    logic signed [ACC_W-1:0] acc_sh;
    logic        [OUT_W-1:0] y_sat;

    // o_y is a pure function of the accumulator flop, so it updates and holds with o_valid.
    always_comb begin
        acc_sh = acc_q >>> SHIFT;
        if (acc_sh > Y_MAX) begin
            y_sat = OUT_W'(Y_MAX);
        end else if (acc_sh < Y_MIN) begin
            y_sat = OUT_W'(Y_MIN);
        end else begin
            y_sat = OUT_W'(acc_sh);
        end
    end

    assign bus.o_y = y_sat;
`else
    assign bus.o_y = OUT_W'(acc_q >>> SHIFT);
`endif
endmodule

// File: doc/fir_filt.md
FIR_FILT -- requirements
Module: fir_filt

Interface
REQ-001 Parameter DATA_W, default 8, input sample width, signed two's complement.
REQ-002 Parameter COEF_W, default 8, coefficient width, signed two's complement.
REQ-003 Parameter TAPS, default 3, tap count, range 2..16.
REQ-004 Parameter OUT_W, default 8, output width.
REQ-005 Parameter SHIFT, default 0, arithmetic right shift applied to the accumulator before output narrowing.
REQ-006 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-007 Port rst, input, 1, asynchronous active-high reset.
REQ-008 Port i_valid, input, 1, i_x carries a new sample this cycle.
REQ-009 Port i_x, input, DATA_W, input sample.
REQ-010 Port coef_we, input, 1, coefficient write strobe.
REQ-011 Port coef_addr, input, clog2(TAPS), tap index written; index 0 multiplies the newest sample.
REQ-012 Port coef_data, input, COEF_W, coefficient value.
REQ-013 Port o_valid, output, 1, o_y carries a new filtered sample.
REQ-014 Port o_y, output, OUT_W, filtered sample.

Function
REQ-015 Delay line of TAPS-1 DATA_W registers shifts only on cycles with i_valid=1; contents hold otherwise.
REQ-016 Stage 1: on i_valid, register all TAPS products coef[k]*x[n-k], each DATA_W+COEF_W bits signed, using current i_x as x[n] and delay-line contents before the shift.
REQ-017 Stage 2: register sum of stage-1 products into accumulator of ACC_W = DATA_W+COEF_W+clog2(TAPS) bits; the sum never overflows.
REQ-018 o_y = (acc >>> SHIFT) narrowed to OUT_W per REQ-029/REQ-030, registered with o_valid.
REQ-019 Latency: o_valid=1 exactly 2 cycles after each i_valid=1; one output per input; no outputs without inputs.
REQ-020 Throughput: one sample per cycle; back-to-back i_valid accepted without stall; no backpressure.
REQ-021 Valid pipeline: v1 <= i_valid, o_valid <= v1; stages 1-2 and o_y hold when their valid input is 0.
REQ-022 Coefficient write: on coef_we, coef[coef_addr] <= coef_data; coef_addr >= TAPS ignored.
REQ-023 Write and sample in same cycle: stage-1 product uses the old coefficient; new value applies from the next sample.
REQ-024 Delay-line registers reset to 0, so the first TAPS-1 outputs after reset reflect zero history.

Reset
REQ-025 rst asserted asynchronously clears delay line, stage-1 products, accumulator, v1, o_valid=0, o_y=0.
REQ-026 rst sets every coefficient to 1 (unity moving-sum filter).
REQ-027 Samples in flight at reset assertion are discarded; no o_valid pulse for them after release.
REQ-028 First i_valid accepted on the first rising clk edge with rst low.

Configuration
REQ-029 Macro FIR_FILT_SAT_EN defined: values above max OUT_W signed clamp to 2^(OUT_W-1)-1, below min clamp to -2^(OUT_W-1).
REQ-030 Macro FIR_FILT_SAT_EN undefined: o_y is the low OUT_W bits of the shifted accumulator (wrap-around).

Verification
REQ-031 Defaults, reset coefs, impulse i_x=1 then 0s, all valid -> o_y = 1,1,1,0,... starting 2 cycles after impulse.
REQ-032 Write coef = {2,-1,3}, impulse i_x=5 -> o_y = 10,-5,15,0.
REQ-033 i_valid pattern 1,0,0,1,0,1 with i_x=1,x,x,2,x,3 -> o_valid pattern delayed by 2 cycles exactly; o_y=1,3,6; o_y holds during gaps.
REQ-034 Coefs {127,127,127}, i_x=127 constant: FIR_FILT_SAT_EN -> o_y=127 steady; without macro -> o_y=low 8 bits of 48387 = 0x03 (3).
REQ-035 rst pulse asserted mid-stream between clock edges -> o_valid and o_y drop to 0 immediately, coefs return to 1, next impulse gives 1,1,1.
REQ-036 coef_we with coef_addr=3 (TAPS=3) -> no coefficient changes; impulse response unchanged.
